// File: rtl/x87_cmd_queue.sv
// x87_cmd_queue: in-order decoded-command FIFO between the x87 opcode decoder and execution unit.
// Build option X87_FWAIT_SYNC_EN: queue FWAIT and hold it at the head until exec_idle.
module x87_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_cmd_valid,
    input  logic [4:0]       in_cmd,
    input  logic [2:0]       in_idx,
    input  logic [31:0]      in_ea,
    output logic             in_ready,
    output logic             ud_pulse,
    output logic             out_valid,
    output logic [4:0]       out_cmd,
    output logic [2:0]       out_idx,
    output logic [31:0]      out_ea,
    input  logic             out_ready,
    input  logic             exec_idle,
    output logic             fwait_stall,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CMD_W = 5;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned EA_W  = 32;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CMD_W-1:0] CMD_FWAIT = CMD_W'(5);

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [IDX_W-1:0] idx;
        logic [EA_W-1:0]  ea;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ud_pulse_q, ud_pulse_d;

    entry_t head;
    logic   full;
    logic   empty;
    logic   head_fwait;
    logic   accept;
    logic   store;
    logic   fwait_retire;
    logic   pop;

    // Head decode and handshake qualification
    always_comb begin
        head       = mem_q[rd_ptr_q];
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        head_fwait = !empty && (head.cmd == CMD_FWAIT);
        accept     = in_valid && !full && !flush;
`ifdef X87_FWAIT_SYNC_EN
        store        = accept && in_cmd_valid;
        fwait_retire = head_fwait && exec_idle;
        fwait_stall  = head_fwait && !exec_idle;
`else
        // FWAIT consumes the handshake but never occupies an entry
        store        = accept && in_cmd_valid && (in_cmd != CMD_FWAIT);
        fwait_retire = 1'b0;
        fwait_stall  = 1'b0;
`endif
        out_valid = !empty && !head_fwait;
        pop       = (out_valid && out_ready) || fwait_retire;
    end

`ifndef X87_FWAIT_SYNC_EN
    logic unused_exec_idle;
    assign unused_exec_idle = exec_idle;
`endif

    // Next-state: flush overrides push/pop; storage contents survive a flush
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ud_pulse_d = accept && !in_cmd_valid;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = '{cmd: in_cmd, idx: in_idx, ea: in_ea};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ud_pulse_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ud_pulse_q <= ud_pulse_d;
        end
    end

    assign in_ready = !full;
    assign ud_pulse = ud_pulse_q;
    assign out_cmd  = head.cmd;
    assign out_idx  = head.idx;
    assign out_ea   = head.ea;
    assign count    = count_q;

endmodule

// File: doc/x87_cmd_queue.md
# x87_cmd_queue

Decoded-command queue between the x87 opcode decoder and the x87 execution unit. It accepts one decoded command per cycle (cmd, idx, effective address) over a valid/ready handshake and buffers up to DEPTH entries in order. It presents the head entry to the execution unit over a second valid/ready handshake. It also enforces FWAIT ordering and flags undecodable opcodes.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH): pointer width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous discard of all entries (pipeline flush or exception).
- in_valid  input  1  decoder output qualified by the front end.
- in_cmd_valid  input  1  decoder cmd_valid.
- in_cmd  input  5  decoder cmd (0..31, same encoding as the execution unit).
- in_idx  input  3  decoder idx.
- in_ea  input  32  memory effective address; don't-care for register forms.
- in_ready  output  1  queue can accept; equals !full.
- ud_pulse  output  1  one-cycle pulse: an undecodable x87 opcode was accepted.
- out_valid  output  1  head entry available for execution.
- out_cmd  output  5  head cmd.
- out_idx  output  3  head idx.
- out_ea  output  32  head effective address.
- out_ready  input  1  execution unit consumes the head.
- exec_idle  input  1  execution unit has no operation in flight.
- fwait_stall  output  1  FWAIT at head is waiting for exec_idle.
- count  output  PTR_W+1  current occupancy.

## Operation
- Storage: DEPTH × 40-bit registers {cmd, idx, ea}, plus write pointer, read pointer and count.
- Accept condition: in_valid && in_ready && !flush.
  - If in_cmd_valid=0: the entry is not stored; ud_pulse=1 for the following cycle.
  - Otherwise: write at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Head presentation is show-ahead:
  - out_cmd/out_idx/out_ea come from entry[rd_ptr].
  - out_valid = (count!=0) && (head cmd != 5).
  - Pop on out_valid && out_ready.
- FWAIT (cmd 5) at head:
  - Not presented to the execution unit.
  - fwait_stall=1 while exec_idle=0.
  - Retired (popped internally) at the first edge where exec_idle=1.
- count update:
  - +1 on push only; −1 on pop only.
  - Unchanged on a simultaneous push and pop. This is allowed only when not full, because in_ready is based on full only.
- flush: wr_ptr, rd_ptr and count go to 0 at the next edge.
  - Takes priority over push and pop in the same cycle.
  - ud_pulse is suppressed for a command presented in the flush cycle.
- Entry contents are not cleared on flush; only the pointers are.
- There is no combinational path from out_ready to in_ready.

## Timing
- Reset (rst_n low, asynchronous): pointers, count and ud_pulse clear to 0.
  - Resulting outputs: in_ready=1, out_valid=0, fwait_stall=0, count=0.
  - out_cmd, out_idx and out_ea read entry 0; storage resets to 0, so they read 0.
- Push at edge N: the entry is visible on out_* with out_valid=1 after edge N, i.e. one cycle from accept to present.
- Pop at edge N: the next entry, if any, is presented after edge N. A back-to-back throughput of 1 command/cycle is sustained.
- Full (count=DEPTH): in_ready=0. A push is impossible even if a pop happens the same cycle. in_ready rises the cycle after the pop.
- Empty: out_valid=0 and fwait_stall=0. Outputs hold stale data.
- FWAIT with exec_idle already 1: retires at the first edge where it is at head. Total cost is 1 cycle after its push.
- Wrap-around: pointers roll DEPTH−1 → 0 with no bubble.
- Reset mid-operation: all contents are abandoned immediately. No ud_pulse is emitted after reset release.

## Configuration
- X87_FWAIT_SYNC_EN defined:
  - FWAIT is queued and held at head until exec_idle, as described above.
  - fwait_stall is functional.
- Not defined:
  - cmd 5 with in_cmd_valid=1 is accepted (it consumes the handshake) but is not stored.
  - fwait_stall is tied to 0.
  - exec_idle is unused.

## Test plan
- Reset then push 4 commands (cmd 6, 10, 20, 31; ea 0x1000+i) with out_ready=0 -> count=4, in_ready=0. Release out_ready -> the four entries pop in order on 4 consecutive cycles; count returns to 0.
- Push with in_cmd_valid=0 -> count stays 0 and ud_pulse=1 for exactly one cycle. The same push during flush -> no ud_pulse.
- With X87_FWAIT_SYNC_EN: push FWAIT (cmd 5) then cmd 20 with exec_idle=0 for 5 cycles -> out_valid=0 and fwait_stall=1 for 5 cycles. Raise exec_idle -> FWAIT retires, cmd 20 is presented on the next cycle. Without the macro: cmd 20 is presented immediately and fwait_stall stays 0.
- Continuous push and pop at DEPTH=4 for 10 commands -> count stays at 1 or below, with no bubble across pointer wrap.
- Queue holding 3 entries, flush asserted together with a push and a pop -> next cycle count=0, out_valid=0, in_ready=1.
- Assert rst_n low asynchronously mid-stream with count=2 -> out_valid, count and fwait_stall drop without waiting for a clock edge. After release, the first push is presented normally.
